perimeter_stats: RTL and testbench
==================================

Name: perimeter_stats

Overview:
- Consumer stage placed directly downstream of the rectangle-perimeter unit.
- Takes 10-bit perimeter values over a /dav-rfd handshake, in batches of N.
- For each batch it produces the sum and the maximum value.
- It hands the batch result to the next consumer over a second /dav-rfd handshake, then clears and starts the next batch.

Parameters:
- N, 4, number of samples per batch (1 <= N <= 64).
- SW, 12, width of sum_out. Must satisfy SW >= 10 + ceil(log2 N).
- CW, 3, width of the internal sample counter. Must satisfy 2^CW > N.

Ports:
- clock  input  1  system clock, posedge active.
- reset_  input  1  asynchronous reset, active-low.
- data_in  input  10  perimeter value from the upstream producer.
- dav_in_  input  1  upstream data valid, active-low.
- rfd_in  output  1  ready-for-data to the upstream producer.
- sum_out  output  SW  batch sum.
- max_out  output  10  batch maximum.
- dav_out_  output  1  result valid to downstream, active-low.
- rfd_out  input  1  downstream ready-for-data.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (reset_). All state and outputs are registers.
- Reset values (asserted immediately on reset_=0): state=S_IDLE, rfd_in=1, dav_out_=1, sum_out=0, max_out=0, acc_sum=0, acc_max=0, cnt=0.
- Reset mid-operation: the partial batch is discarded and a pending output is withdrawn (dav_out_=1).
- State machine, all transitions evaluated at posedge clock:
  - S_IDLE: rfd_in=1, dav_out_=1.
    - If dav_in_==0: acc_sum += data_in, acc_max = max(acc_max, data_in), cnt += 1; go to S_ACK.
    - Otherwise stay in S_IDLE.
  - S_ACK: rfd_in=0. Wait for dav_in_==1.
    - If cnt==N: sum_out<=acc_sum, max_out<=acc_max; go to S_OFFER.
    - Otherwise go to S_IDLE.
  - S_OFFER: rfd_in=0, dav_out_=1, outputs stable. When rfd_out==1, go to S_VALID.
  - S_VALID: dav_out_=0. When rfd_out==0: clear acc_sum, acc_max and cnt; go to S_IDLE with dav_out_=1.
- data_in is sampled exactly once per handshake, on the clock edge where dav_in_==0 is first seen in S_IDLE.
- A dav_in_ held low for many cycles still counts as a single sample.
- No new input is accepted from the end of sample N until the downstream handshake completes (backpressure propagates upstream).
- Arithmetic:
  - All values are unsigned. acc_sum is SW bits and never overflows, given the parameter constraint.
  - Max comparison is unsigned; on equal values acc_max is unchanged.
  - Odd input values are accepted unmodified.
- sum_out and max_out change only on the S_ACK->S_OFFER transition and on reset. They hold through S_VALID and the following batch.
- Output transitions are registered: rfd_in and dav_out_ change on the edge that enters the corresponding state, never combinationally from inputs.
- Minimum cost per accepted sample is 2 clocks. Minimum cost per batch is 2N+2 clocks, excluding handshake waits.

Test Plan:
- N=4; inputs 20, 100, 1020, 0 with well-behaved handshakes -> sum_out=1140, max_out=1020, dav_out_=0 after rfd_out=1.
- N=4; four inputs of 1023 -> sum_out=4092 (0xFFC), max_out=1023, no overflow.
- Second batch 2, 2, 2, 2 after the first completes -> sum_out=8, max_out=2. Confirms accumulators cleared and previous outputs held until the new load.
- rfd_out held 0 for 20 clocks after the 4th sample -> dav_out_ stays 1 and rfd_in stays 0. A 5th dav_in_=0 is not sampled until the batch is consumed.
- dav_in_ held low 10 clocks for one value of 50 -> cnt increments by 1 only. rfd_in=0 until dav_in_ returns to 1.
- reset_ pulsed low after 2 samples (10, 20), then samples 1, 2, 3, 4 -> sum_out=10, max_out=4. During reset: rfd_in=1, dav_out_=1, outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/perimeter_stats_if.sv
// Handshake bundle between the perimeter-statistics stage and its neighbours.
// The upstream side carries data_in with dav_in_/rfd_in. The downstream side
// carries sum_out/max_out with dav_out_/rfd_out. The slave modport is the
// statistics stage; the master modport is whoever drives it (producer plus
// consumer, or a testbench).
interface perimeter_stats_if #(
  parameter int SW = 12
);
  logic [9:0]    data_in;
  logic          dav_in_;
  logic          rfd_in;
  logic [SW-1:0] sum_out;
  logic [9:0]    max_out;
  logic          dav_out_;
  logic          rfd_out;

  modport slave (
    input  data_in, dav_in_, rfd_out,
    output rfd_in, sum_out, max_out, dav_out_
  );

  modport master (
    output data_in, dav_in_, rfd_out,
    input  rfd_in, sum_out, max_out, dav_out_
  );
endinterface

// File: rtl/perimeter_stats.sv
// Batch statistics stage. It accepts N perimeter values over an active-low
// dav / rfd handshake and accumulates their sum and maximum. It then offers
// the result downstream over a second handshake and starts the next batch
// once that handshake completes. While a result is pending, no further
// input is accepted, so backpressure propagates to the producer.
module perimeter_stats #(
  parameter int N  = 4,
  parameter int SW = 12,
  parameter int CW = 3
) (
  input  logic clock,
  input  logic reset_,
  perimeter_stats_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_OFFER,
    S_VALID
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(N);

  state_t        state;
  logic [SW-1:0] acc_sum;
  logic [9:0]    acc_max;
  logic [CW-1:0] cnt;

  // Handshake sequencing and accumulation. Every output is a register set on
  // the edge that enters its state.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state        <= S_IDLE;
      bus.rfd_in   <= 1'b1;
      bus.dav_out_ <= 1'b1;
      bus.sum_out  <= '0;
      bus.max_out  <= '0;
      acc_sum      <= '0;
      acc_max      <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.dav_in_) begin
            acc_sum    <= acc_sum + SW'(bus.data_in);
            if (bus.data_in > acc_max) begin
              acc_max <= bus.data_in;
            end
            cnt        <= cnt + 1'b1;
            bus.rfd_in <= 1'b0;
            state      <= S_ACK;
          end
        end
        S_ACK: begin
          if (bus.dav_in_) begin
            if (cnt == LAST_CNT) begin
              bus.sum_out <= acc_sum;
              bus.max_out <= acc_max;
              state       <= S_OFFER;
            end else begin
              bus.rfd_in <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        S_OFFER: begin
          if (bus.rfd_out) begin
            bus.dav_out_ <= 1'b0;
            state        <= S_VALID;
          end
        end
        S_VALID: begin
          if (!bus.rfd_out) begin
            acc_sum      <= '0;
            acc_max      <= '0;
            cnt          <= '0;
            bus.dav_out_ <= 1'b1;
            bus.rfd_in   <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perimeter_stats.sv
// Self-checking bench for perimeter_stats. A behavioural model collects each
// batch in a queue. When the batch is full, the model computes the expected
// sum and maximum with plain arithmetic. Each scenario task does its own checks.
module tb_perimeter_stats;

  localparam int N   = 4;
  localparam int SW  = 12;
  localparam int CW  = 3;
  localparam int TMO = 200;

  logic clock  = 1'b0;
  logic reset_ = 1'b1;

  perimeter_stats_if #(.SW(SW)) bus ();

  perimeter_stats #(.N(N), .SW(SW), .CW(CW)) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: samples of the batch in progress, plus the results the
  // DUT should be holding on sum_out / max_out.
  int batch_q[$];
  int exp_sum = 0;
  int exp_max = 0;

  task automatic model_push(input int value);
    int s;
    int m;
    batch_q.push_back(value);
    if (batch_q.size() == N) begin
      s = 0;
      m = 0;
      foreach (batch_q[i]) begin
        s += batch_q[i];
        if (batch_q[i] > m) m = batch_q[i];
      end
      exp_sum = s;
      exp_max = m;
      batch_q.delete();
    end
  endtask

  // Producer side of one upstream handshake. hold keeps dav_in_ low for that
  // many extra cycles after the DUT acknowledges.
  task automatic send_sample(input int value, input int hold);
    int t;
    t = 0;
    @(negedge clock);
    while (bus.rfd_in !== 1'b1 && t < TMO) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (t >= TMO) begin
      n_err++;
      $display("[TB] FAIL send_rfd_wait: rfd_in=%b, required 1 within %0d cycles", bus.rfd_in, TMO);
      return;
    end
    bus.data_in = 10'(value);
    bus.dav_in_ = 1'b0;
    @(negedge clock);
    t = 0;
    while (bus.rfd_in !== 1'b0 && t < TMO) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (t >= TMO) begin
      n_err++;
      $display("[TB] FAIL send_ack_wait: rfd_in=%b, required 0 within %0d cycles", bus.rfd_in, TMO);
    end
    repeat (hold) @(negedge clock);
    bus.dav_in_ = 1'b1;
    model_push(value);
  endtask

  // Consumer side: raise rfd_out and wait for the result to be offered.
  task automatic take_result(input int delay);
    int t;
    repeat (delay) @(negedge clock);
    bus.rfd_out = 1'b1;
    t = 0;
    @(negedge clock);
    while (bus.dav_out_ !== 1'b0 && t < TMO) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (t >= TMO) begin
      n_err++;
      $display("[TB] FAIL result_wait: dav_out_=%b, required 0 within %0d cycles", bus.dav_out_, TMO);
    end
  endtask

  // Consumer side: drop rfd_out and wait for the DUT to withdraw dav_out_.
  task automatic release_result();
    int t;
    bus.rfd_out = 1'b0;
    t = 0;
    @(negedge clock);
    while (bus.dav_out_ !== 1'b1 && t < TMO) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (t >= TMO) begin
      n_err++;
      $display("[TB] FAIL release_wait: dav_out_=%b, required 1 within %0d cycles", bus.dav_out_, TMO);
    end
  endtask

  task automatic test_reset();
    #1 reset_ = 1'b0;
    #2;
    n_vec++;
    if (bus.rfd_in !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_rfd_in: got %b, want 1", bus.rfd_in);
    end
    n_vec++;
    if (bus.dav_out_ !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_dav_out: got %b, want 1", bus.dav_out_);
    end
    n_vec++;
    if (bus.sum_out !== SW'(0)) begin
      n_err++; $display("[TB] FAIL reset_sum: got %0d, want 0", bus.sum_out);
    end
    n_vec++;
    if (bus.max_out !== 10'd0) begin
      n_err++; $display("[TB] FAIL reset_max: got %0d, want 0", bus.max_out);
    end
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_directed();
    int vals[4] = '{20, 100, 1020, 0};
    foreach (vals[i]) send_sample(vals[i], 0);
    take_result(0);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum) || exp_sum != 1140) begin
      n_err++; $display("[TB] FAIL directed_sum: got %0d, want 1140 (model %0d)", bus.sum_out, exp_sum);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max) || exp_max != 1020) begin
      n_err++; $display("[TB] FAIL directed_max: got %0d, want 1020 (model %0d)", bus.max_out, exp_max);
    end
    release_result();
  endtask

  task automatic test_all_max();
    repeat (N) send_sample(1023, 0);
    take_result(1);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum)) begin
      n_err++; $display("[TB] FAIL allmax_sum: got %0d, want %0d", bus.sum_out, exp_sum);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max)) begin
      n_err++; $display("[TB] FAIL allmax_max: got %0d, want %0d", bus.max_out, exp_max);
    end
    release_result();
  endtask

  task automatic test_second_batch();
    repeat (N - 1) send_sample(2, 0);
    repeat (3) @(negedge clock);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum)) begin
      n_err++; $display("[TB] FAIL held_sum: got %0d, want %0d", bus.sum_out, exp_sum);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max)) begin
      n_err++; $display("[TB] FAIL held_max: got %0d, want %0d", bus.max_out, exp_max);
    end
    send_sample(2, 0);
    take_result(0);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum)) begin
      n_err++; $display("[TB] FAIL second_sum: got %0d, want %0d", bus.sum_out, exp_sum);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max)) begin
      n_err++; $display("[TB] FAIL second_max: got %0d, want %0d", bus.max_out, exp_max);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int t;
    int bad;
    for (int i = 0; i < N; i++) send_sample(100 + i, 0);
    @(negedge clock);
    bus.data_in = 10'd7;
    bus.dav_in_ = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_vec++;
      if (bus.dav_out_ !== 1'b1 || bus.rfd_in !== 1'b0) begin
        n_err++;
        bad++;
        if (bad < 4) $display("[TB] FAIL stall_cycle%0d: dav_out_=%b rfd_in=%b, want 1 and 0", c, bus.dav_out_, bus.rfd_in);
      end
    end
    take_result(0);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum)) begin
      n_err++; $display("[TB] FAIL stall_sum: got %0d, want %0d", bus.sum_out, exp_sum);
    end
    release_result();
    t = 0;
    while (bus.rfd_in !== 1'b0 && t < TMO) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (t >= TMO) begin
      n_err++; $display("[TB] FAIL stall_fifth_ack: rfd_in=%b, want 0", bus.rfd_in);
    end
    bus.dav_in_ = 1'b1;
    model_push(7);
    for (int i = 0; i < N - 1; i++) send_sample(300 + 11 * i, 0);
    take_result(0);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum)) begin
      n_err++; $display("[TB] FAIL stall_next_sum: got %0d, want %0d", bus.sum_out, exp_sum);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max)) begin
      n_err++; $display("[TB] FAIL stall_next_max: got %0d, want %0d", bus.max_out, exp_max);
    end
    release_result();
  endtask

  task automatic test_long_dav();
    int bad;
    @(negedge clock);
    bus.data_in = 10'd50;
    bus.dav_in_ = 1'b0;
    @(negedge clock);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_vec++;
      if (bus.rfd_in !== 1'b0) begin
        n_err++;
        bad++;
        if (bad < 4) $display("[TB] FAIL longdav_rfd%0d: got %b, want 0", c, bus.rfd_in);
      end
    end
    bus.dav_in_ = 1'b1;
    model_push(50);
    send_sample(5, 0);
    send_sample(900, 2);
    send_sample(1, 0);
    take_result(2);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum)) begin
      n_err++; $display("[TB] FAIL longdav_sum: got %0d, want %0d", bus.sum_out, exp_sum);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max)) begin
      n_err++; $display("[TB] FAIL longdav_max: got %0d, want %0d", bus.max_out, exp_max);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    send_sample(10, 0);
    send_sample(20, 0);
    @(negedge clock);
    #2 reset_ = 1'b0;
    #1;
    n_vec++;
    if (bus.rfd_in !== 1'b1 || bus.dav_out_ !== 1'b1) begin
      n_err++; $display("[TB] FAIL midreset_hs: rfd_in=%b dav_out_=%b, want 1 and 1", bus.rfd_in, bus.dav_out_);
    end
    n_vec++;
    if (bus.sum_out !== SW'(0) || bus.max_out !== 10'd0) begin
      n_err++; $display("[TB] FAIL midreset_out: sum=%0d max=%0d, want 0 and 0", bus.sum_out, bus.max_out);
    end
    batch_q.delete();
    exp_sum = 0;
    exp_max = 0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    for (int v = 1; v <= N; v++) send_sample(v, 0);
    take_result(0);
    n_vec++;
    if (bus.sum_out !== SW'(exp_sum) || exp_sum != 10) begin
      n_err++; $display("[TB] FAIL midreset_sum: got %0d, want 10", bus.sum_out);
    end
    n_vec++;
    if (bus.max_out !== 10'(exp_max) || exp_max != 4) begin
      n_err++; $display("[TB] FAIL midreset_max: got %0d, want 4", bus.max_out);
    end
    #2 reset_ = 1'b0;
    #1;
    n_vec++;
    if (bus.dav_out_ !== 1'b1) begin
      n_err++; $display("[TB] FAIL withdraw_dav: got %b, want 1", bus.dav_out_);
    end
    bus.rfd_out = 1'b0;
    exp_sum = 0;
    exp_max = 0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        send_sample(int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)));
      end
      take_result(int'($urandom_range(0, 4)));
      n_vec++;
      if (bus.sum_out !== SW'(exp_sum)) begin
        n_err++; $display("[TB] FAIL rand%0d_sum: got %0d, want %0d", b, bus.sum_out, exp_sum);
      end
      n_vec++;
      if (bus.max_out !== 10'(exp_max)) begin
        n_err++; $display("[TB] FAIL rand%0d_max: got %0d, want %0d", b, bus.max_out, exp_max);
      end
      release_result();
    end
  endtask

  // Scenario sequence.
  initial begin
    bus.data_in = 10'd0;
    bus.dav_in_ = 1'b1;
    bus.rfd_out = 1'b0;
    test_reset();
    test_directed();
    test_all_max();
    test_second_batch();
    test_backpressure();
    test_long_dav();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
